// File: rtl/rob_squash_pkg.sv
// sys_defs: shared ROB payload and debug-bundle types.
package sys_defs;
  localparam int ROB_DATA_W = 64;
  localparam int ROB_DBG_W = 8;
  typedef logic [ROB_DATA_W-1:0] ROB_ENTRY_PACKET;
  typedef struct packed {
    logic [ROB_DBG_W-1:0] head;
    logic [ROB_DBG_W-1:0] tail;
    logic [ROB_DBG_W:0]   num_entries;
    logic [ROB_DBG_W-1:0] spots;
  } ROB_DEBUG;
endpackage

// File: rtl/rob_squash_if.sv
// rob_squash_if: dispatch/complete/retire/squash bundle of the ROB.
interface rob_squash_if #(
  parameter int N = 2,
  parameter int DATA_W = 64,
  parameter int IDX_W = 5,
  parameter int SC_W = 2,
  parameter int CNT_W = 6
);
  import sys_defs::*;
  logic [N-1:0][DATA_W-1:0] in_data;
  logic [SC_W-1:0]          in_valid;
  logic [SC_W-1:0]          spots;
  logic [N-1:0][DATA_W-1:0] out_data;
  logic [N-1:0]             out_done;
  logic [SC_W-1:0]          out_valid;
  logic [SC_W-1:0]          num_retiring;
  logic [N-1:0]             cmp_en;
  logic [N-1:0][IDX_W-1:0]  cmp_idx;
  logic                     squash_en;
  logic [IDX_W-1:0]         squash_idx;
  logic [IDX_W-1:0]         head_idx;
  logic [IDX_W-1:0]         tail_idx;
  logic [CNT_W-1:0]         num_entries;
  ROB_DEBUG                 debug;
  modport master (
    output in_data, in_valid, num_retiring, cmp_en, cmp_idx, squash_en, squash_idx,
    input  spots, out_data, out_done, out_valid, head_idx, tail_idx, num_entries, debug
  );
  modport slave (
    input  in_data, in_valid, num_retiring, cmp_en, cmp_idx, squash_en, squash_idx,
    output spots, out_data, out_done, out_valid, head_idx, tail_idx, num_entries, debug
  );
endinterface

// File: rtl/rob_squash_ptr_wrap.sv
// rob_ptr_wrap: pointer plus slot count, wrapping mod 2**IDX_W.
module rob_ptr_wrap #(
  parameter int IDX_W = 5,
  parameter int SC_W = 2
) (
  input  logic [IDX_W-1:0] ptr,
  input  logic [SC_W-1:0]  cnt,
  output logic [IDX_W-1:0] sum
);
  assign sum = ptr + IDX_W'(cnt);
endmodule

// File: rtl/rob_squash.sv
// rob_squash: circular reorder buffer with completion, retire and mispredict rollback.
module rob_squash
  import sys_defs::*;
#(
  parameter int DEPTH = 32,
  parameter int N = 2,
  parameter int DATA_W = 64,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int SC_W = $clog2(N + 1)
) (
  input logic clock,
  input logic reset,
  rob_squash_if.slave io
);
  logic [IDX_W-1:0]  head, tail, head_n, tail_adv, sq_next, sq_off;
  logic [CNT_W-1:0]  count, count_n, free, keep;
  logic [DEPTH-1:0]  done;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  disp_idx [N];
  logic [IDX_W-1:0]  out_idx [N];
  logic [IDX_W-1:0]  cmp_off [N];
  logic [N-1:0]      cmp_ok;
  rob_ptr_wrap #(.IDX_W(IDX_W), .SC_W(SC_W)) u_head (.ptr(head), .cnt(io.num_retiring), .sum(head_n));
  rob_ptr_wrap #(.IDX_W(IDX_W), .SC_W(SC_W)) u_tail (.ptr(tail), .cnt(io.in_valid), .sum(tail_adv));
  rob_ptr_wrap #(.IDX_W(IDX_W), .SC_W(SC_W)) u_sq (.ptr(io.squash_idx), .cnt(SC_W'(1)), .sum(sq_next));
  for (genvar i = 0; i < N; i++) begin : g_slot
    rob_ptr_wrap #(.IDX_W(IDX_W), .SC_W(SC_W)) u_disp (.ptr(tail), .cnt(SC_W'(i)), .sum(disp_idx[i]));
    rob_ptr_wrap #(.IDX_W(IDX_W), .SC_W(SC_W)) u_out (.ptr(head), .cnt(SC_W'(i)), .sum(out_idx[i]));
    assign io.out_data[i] = mem[out_idx[i]];
    assign io.out_done[i] = done[out_idx[i]];
  end
  // liveness is judged by distance from head, so full and empty never alias
  always_comb begin
    sq_off = io.squash_idx - head;
    keep = CNT_W'(sq_off) + CNT_W'(1);
    free = CNT_W'(DEPTH) - count;
    for (int i = 0; i < N; i++) begin
      cmp_off[i] = io.cmp_idx[i] - head;
      cmp_ok[i] = io.cmp_en[i] && (CNT_W'(cmp_off[i]) < count) && !(io.squash_en && (cmp_off[i] > sq_off));
    end
    count_n = io.squash_en ? keep - CNT_W'(io.num_retiring)
                           : count + CNT_W'(io.in_valid) - CNT_W'(io.num_retiring);
  end
  assign io.spots = (free >= CNT_W'(N)) ? SC_W'(N) : SC_W'(free);
  assign io.out_valid = (count >= CNT_W'(N)) ? SC_W'(N) : SC_W'(count);
  assign io.head_idx = head;
  assign io.tail_idx = tail;
  assign io.num_entries = count;
  assign io.debug = '{head: ROB_DBG_W'(head), tail: ROB_DBG_W'(tail),
                      num_entries: (ROB_DBG_W+1)'(count), spots: ROB_DBG_W'(io.spots)};
  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      done <= '0;
    end else begin
      head <= head_n;
      tail <= io.squash_en ? sq_next : tail_adv;
      count <= count_n;
      for (int i = 0; i < N; i++) begin
        if (!io.squash_en && (SC_W'(i) < io.in_valid)) done[disp_idx[i]] <= 1'b0;
        if (cmp_ok[i]) done[io.cmp_idx[i]] <= 1'b1;
      end
    end
  end
  always_ff @(posedge clock)
    for (int i = 0; i < N; i++)
      if (!io.squash_en && (SC_W'(i) < io.in_valid)) mem[disp_idx[i]] <= io.in_data[i];
endmodule

// File: tb/tb_rob_squash.sv
// tb_rob_squash: directed table plus hand-written sequences for the ROB.
module tb_rob_squash;
  import sys_defs::*;
  localparam int N = 2, DEPTH = 32, DATA_W = 64, IDX_W = 5, SC_W = 2, CNT_W = 6;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  rob_squash_if #(.N(N), .DATA_W(DATA_W), .IDX_W(IDX_W), .SC_W(SC_W), .CNT_W(CNT_W)) bus ();
  rob_squash #(.DEPTH(DEPTH), .N(N), .DATA_W(DATA_W)) dut (.clock(clock), .reset(reset), .io(bus));
  typedef struct {
    int v, ret;
    logic [1:0] ce;
    int c0, c1;
    logic sq;
    int si, h, t, ne, sp, ov;
    logic [1:0] dn;
  } vec_t;
  vec_t tbl [7];
  int checks = 0;
  int failures = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step(input int v, input int tag, input int ret, input logic [1:0] ce,
                      input int c0, input int c1, input logic sq, input int si);
    bus.in_valid = SC_W'(v);
    bus.in_data[0] = 64'(tag);
    bus.in_data[1] = 64'(tag + 1);
    bus.num_retiring = SC_W'(ret);
    bus.cmp_en = ce;
    bus.cmp_idx[0] = IDX_W'(c0);
    bus.cmp_idx[1] = IDX_W'(c1);
    bus.squash_en = sq;
    bus.squash_idx = IDX_W'(si);
    @(posedge clock);
    #1;
  endtask
  task automatic idle();
    step(0, 0, 0, 2'b00, 0, 0, 1'b0, 0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    idle();
    reset = 1'b0;
  endtask
  task automatic check_state(input string tag, input int h, input int t, input int ne, input int sp, input int ov);
    check({tag, " head"}, 64'(bus.head_idx), 64'(h));
    check({tag, " tail"}, 64'(bus.tail_idx), 64'(t));
    check({tag, " num_entries"}, 64'(bus.num_entries), 64'(ne));
    check({tag, " spots"}, 64'(bus.spots), 64'(sp));
    check({tag, " out_valid"}, 64'(bus.out_valid), 64'(ov));
  endtask
  initial begin
    logic [1:0] dm;
    tbl[0] = '{v:2, ret:0, ce:2'b00, c0:0, c1:0, sq:0, si:0, h:0, t:2, ne:2, sp:2, ov:2, dn:2'b00};
    tbl[1] = '{v:1, ret:0, ce:2'b01, c0:0, c1:0, sq:0, si:0, h:0, t:3, ne:3, sp:2, ov:2, dn:2'b01};
    tbl[2] = '{v:0, ret:0, ce:2'b11, c0:1, c1:5, sq:0, si:0, h:0, t:3, ne:3, sp:2, ov:2, dn:2'b11};
    tbl[3] = '{v:2, ret:2, ce:2'b00, c0:0, c1:0, sq:0, si:0, h:2, t:5, ne:3, sp:2, ov:2, dn:2'b00};
    tbl[4] = '{v:2, ret:0, ce:2'b01, c0:3, c1:0, sq:1, si:2, h:2, t:3, ne:1, sp:2, ov:1, dn:2'b00};
    tbl[5] = '{v:0, ret:0, ce:2'b01, c0:2, c1:0, sq:0, si:0, h:2, t:3, ne:1, sp:2, ov:1, dn:2'b01};
    tbl[6] = '{v:0, ret:1, ce:2'b00, c0:0, c1:0, sq:0, si:0, h:3, t:3, ne:0, sp:2, ov:0, dn:2'b00};
    idle();
    do_reset();
    check_state("reset", 0, 0, 0, 2, 0);
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].v, 100 + 2 * i, tbl[i].ret, tbl[i].ce, tbl[i].c0, tbl[i].c1, tbl[i].sq, tbl[i].si);
      check_state($sformatf("vec%0d", i), tbl[i].h, tbl[i].t, tbl[i].ne, tbl[i].sp, tbl[i].ov);
      dm = (tbl[i].ov == 2) ? 2'b11 : (tbl[i].ov == 1) ? 2'b01 : 2'b00;
      check($sformatf("vec%0d out_done", i), 64'(bus.out_done & dm), 64'(tbl[i].dn & dm));
    end
    do_reset();
    for (int k = 0; k < 16; k++) step(2, 2 * k, 0, 2'b00, 0, 0, 1'b0, 0);
    check_state("fill", 0, 0, 32, 0, 2);
    check("fill data0", bus.out_data[0], 64'd0);
    check("fill data1", bus.out_data[1], 64'd1);
    check("fill debug count", 64'(bus.debug.num_entries), 64'd32);
    check("fill debug spots", 64'(bus.debug.spots), 64'd0);
    for (int k = 0; k < 16; k++) step(0, 0, 0, 2'b11, 2 * k, 2 * k + 1, 1'b0, 0);
    check("all done", 64'(bus.out_done), 64'd3);
    for (int k = 0; k < 40; k++) begin
      check($sformatf("stream%0d data0", k), bus.out_data[0], 64'(2 * k));
      check($sformatf("stream%0d data1", k), bus.out_data[1], 64'(2 * k + 1));
      check($sformatf("stream%0d done", k), 64'(bus.out_done), 64'd3);
      step(2, 32 + 2 * k, 2, (k > 0) ? 2'b11 : 2'b00, (2 * k + 30) % 32, (2 * k + 31) % 32, 1'b0, 0);
      check($sformatf("stream%0d count", k), 64'(bus.num_entries), 64'd32);
    end
    check_state("stream end", 16, 16, 32, 0, 2);
    do_reset();
    for (int k = 0; k < 15; k++) step(2, 2 * k, 0, 2'b00, 0, 0, 1'b0, 0);
    for (int k = 0; k < 15; k++) step(0, 0, 0, 2'b11, 2 * k, 2 * k + 1, 1'b0, 0);
    for (int k = 0; k < 15; k++) step(0, 0, 2, 2'b00, 0, 0, 1'b0, 0);
    check_state("drain30", 30, 30, 0, 2, 0);
    for (int k = 0; k < 3; k++) step(2, 200 + 2 * k, 0, 2'b00, 0, 0, 1'b0, 0);
    check_state("wrap6", 30, 4, 6, 2, 2);
    step(2, 900, 0, 2'b00, 0, 0, 1'b1, 1);
    check_state("squash wrap", 30, 2, 4, 2, 2);
    check("squash wrap data0", bus.out_data[0], 64'd200);
    check("squash wrap data1", bus.out_data[1], 64'd201);
    idle();
    check_state("squash wrap hold", 30, 2, 4, 2, 2);
    do_reset();
    for (int k = 0; k < 7; k++) step(2, 2 * k, 0, 2'b00, 0, 0, 1'b0, 0);
    step(0, 0, 0, 2'b11, 0, 1, 1'b0, 0);
    step(0, 0, 0, 2'b11, 2, 3, 1'b0, 0);
    step(0, 0, 0, 2'b11, 4, 5, 1'b0, 0);
    step(0, 0, 0, 2'b11, 6, 6, 1'b0, 0);
    step(0, 0, 2, 2'b00, 0, 0, 1'b0, 0);
    step(0, 0, 2, 2'b00, 0, 0, 1'b0, 0);
    step(0, 0, 1, 2'b00, 0, 0, 1'b0, 0);
    check_state("pre mix", 5, 14, 9, 2, 2);
    step(0, 0, 2, 2'b01, 12, 0, 1'b1, 9);
    check_state("retire+squash", 7, 10, 3, 2, 2);
    check("retire+squash done", 64'(bus.out_done), 64'd0);
    check("retire+squash data0", bus.out_data[0], 64'd7);
    do_reset();
    step(2, 0, 0, 2'b00, 0, 0, 1'b0, 0);
    step(2, 2, 0, 2'b00, 0, 0, 1'b0, 0);
    step(1, 4, 0, 2'b00, 0, 0, 1'b0, 0);
    step(0, 0, 0, 2'b11, 0, 1, 1'b0, 0);
    step(0, 0, 0, 2'b01, 2, 2, 1'b0, 0);
    step(0, 0, 2, 2'b00, 0, 0, 1'b0, 0);
    step(0, 0, 1, 2'b00, 0, 0, 1'b0, 0);
    check_state("head3", 3, 5, 2, 2, 2);
    step(0, 0, 0, 2'b01, 4, 0, 1'b0, 0);
    check("young done", 64'(bus.out_done), 64'd2);
    idle();
    check_state("blocked", 3, 5, 2, 2, 2);
    check("blocked done", 64'(bus.out_done), 64'd2);
    step(0, 0, 0, 2'b10, 0, 3, 1'b0, 0);
    check("head done", 64'(bus.out_done), 64'd3);
    step(0, 0, 2, 2'b00, 0, 0, 1'b0, 0);
    check_state("drained", 5, 5, 0, 2, 0);
    do_reset();
    for (int k = 0; k < 8; k++) step(2, 2 * k, 0, 2'b00, 0, 0, 1'b0, 0);
    step(1, 16, 0, 2'b00, 0, 0, 1'b0, 0);
    check("mid fill count", 64'(bus.num_entries), 64'd17);
    reset = 1'b1;
    step(2, 50, 0, 2'b11, 0, 1, 1'b1, 3);
    reset = 1'b0;
    check_state("mid reset", 0, 0, 0, 2, 0);
    check("mid reset debug", 64'(bus.debug.num_entries), 64'd0);
    step(2, 60, 0, 2'b00, 0, 0, 1'b0, 0);
    check_state("post reset", 0, 2, 2, 2, 2);
    check("post reset done", 64'(bus.out_done), 64'd0);
    check("post reset data0", bus.out_data[0], 64'd60);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rob_squash.md
ROB_SQUASH -- requirements
Module: rob_squash

Interface
REQ-001 Parameter DEPTH, default 32, number of ROB entries; power of two, >= 2*N.
REQ-002 Parameter N, default 2, dispatch/complete/retire superscalar width.
REQ-003 Parameter DATA_W, default 64, opaque payload bits per entry.
REQ-004 Derived: IDX_W = clog2(DEPTH), CNT_W = clog2(DEPTH+1), SC_W = clog2(N+1).
REQ-005 clock  in  1  rising-edge clock.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 in_data  in  N x DATA_W  dispatch payloads, slot 0 oldest.
REQ-008 in_valid  in  SC_W  count of valid dispatch slots (slots 0..in_valid-1).
REQ-009 spots  out  SC_W  dispatch slots available this cycle.
REQ-010 out_data  out  N x DATA_W  oldest N entries, slot 0 = head.
REQ-011 out_done  out  N  completion flag per output slot.
REQ-012 out_valid  out  SC_W  count of live output slots.
REQ-013 num_retiring  in  SC_W  entries to free from head.
REQ-014 cmp_en  in  N  completion strobes.
REQ-015 cmp_idx  in  N x IDX_W  ROB index being completed per strobe.
REQ-016 squash_en  in  1  branch mispredict rollback request.
REQ-017 squash_idx  in  IDX_W  youngest entry to keep; all younger discarded.
REQ-018 head_idx, tail_idx  out  IDX_W each  current pointers (tail = next free).
REQ-019 num_entries  out  CNT_W  live entry count.

Function
REQ-020 spots SHALL equal min(N, DEPTH - num_entries), from registered state only (no combinational path from any input).
REQ-021 out_valid SHALL equal min(N, num_entries); out_data/out_done for slots >= out_valid are don't-care.
REQ-022 Dispatch: in_valid entries written at tail..tail+in_valid-1 (mod DEPTH), done cleared; tail advances by in_valid; in_valid > spots is illegal.
REQ-023 Retire: head advances by num_retiring mod DEPTH; num_retiring > out_valid, or retiring an entry with out_done=0, is illegal.
REQ-024 Completion: each cmp_en[i] sets done at cmp_idx[i] next cycle iff that index is live and not being squashed away this cycle; otherwise ignored; duplicate indices legal.
REQ-025 Squash: next tail = squash_idx+1 mod DEPTH; dispatch in the same cycle SHALL be dropped; retire in the same cycle still applies.
REQ-026 squash_idx SHALL be live and not among retiring entries; otherwise illegal.
REQ-027 num_entries next = num_entries + dispatched - num_retiring (no squash), or ((squash_idx - head + 1) mod DEPTH, with 0 mapped to DEPTH) - num_retiring (squash).
REQ-028 Full (num_entries=DEPTH, head=tail) and empty (0, head=tail) SHALL be distinguished by count, not pointers.
REQ-029 Pointer arithmetic SHALL wrap mod DEPTH; dispatch/retire blocks may straddle index DEPTH-1 -> 0.
REQ-030 Dispatch into a slot freed by retire in the same cycle is permitted only after spots, i.e. next cycle.
REQ-031 Latency: all state updates visible one cycle after the sampling edge.

Reset
REQ-032 On reset: head_idx=0, tail_idx=0, num_entries=0, all done bits 0, spots=N, out_valid=0; reset overrides squash/dispatch/retire/completion in the same cycle.
REQ-033 Payload storage need not be reset.

Structure
REQ-034 ROB_ENTRY_PACKET payload type and ROB_DEBUG (head, tail, num_entries, spots) typedefs SHALL live in the shared sys_defs package.
REQ-035 One sub-module, rob_ptr_wrap (modular add of IDX_W pointer and SC_W count), SHALL be instantiated for head, tail and output-slot indices.
REQ-036 A ROB_DEBUG output bundle SHALL mirror internal pointers for the existing SVA checker.

Verification
REQ-037 Reset, dispatch 2/cycle for 16 cycles, no retire -> num_entries=32, spots=0, head=tail=0.
REQ-038 Fill 32, complete all, retire 2/cycle while dispatching 2/cycle for 40 cycles -> wrap twice, out_data in dispatch order, num_entries constant 32.
REQ-039 head=30, 6 live entries (30..3), squash_idx=1 with in_valid=2 -> tail=2, num_entries=4, dispatch dropped.
REQ-040 Same cycle: retire 2 at head=5, squash_idx=9, cmp_idx=12 -> head=7, tail=10, num_entries=3, index 12 done stays 0.
REQ-041 Complete idx 4 only among entries 3,4 at head -> out_done=01b-pattern slot1=1, slot0=0; retire 0 until idx 3 completes.
REQ-042 Assert reset mid-fill (num_entries=17, squash_en=1) -> next cycle all outputs at REQ-032 values.
